// File: rtl/ifetch_queue_if.sv
// Fetch-side bus bundle: memory request/response channel plus the instruction
// stream toward the datapath. master = ifetch_queue, slave = memory/datapath side.
interface ifetch_queue_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: credit-limited in-order word fetch, DEPTH-entry
// PC-tagged queue, redirect flush. Define IFQ_BYPASS_EN for same-cycle response bypass.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           redirect,
  input  logic [63:0]    redirect_pc,
  ifetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic [31:0] data;
    logic [63:0] pc;
  } entry_t;

  logic        run_q, run_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] rsp_pc_q, rsp_pc_d;
  cnt_t        in_flight_q, in_flight_d;
  cnt_t        drop_cnt_q, drop_cnt_d;
  cnt_t        count_q, count_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  entry_t      store_q [DEPTH];
  entry_t      store_d [DEPTH];

  logic [63:0] redirect_addr;
  logic        req_valid, req_fire;
  logic        rsp_drop, rsp_keep;
  logic        head_valid, bypass, push, pop;

  // Credits cover requests in flight plus entries queued, so a push always has room.
  always_comb begin
    redirect_addr = redirect_pc & ~64'h3;
    req_valid     = run_q && !redirect && ((in_flight_q + count_q) < cnt_t'(DEPTH));
    req_fire      = req_valid && bus.mem_req_ready;
    rsp_drop      = (drop_cnt_q != '0);
    rsp_keep      = bus.mem_rsp_valid && !rsp_drop && !redirect;
    head_valid    = (count_q != '0);
`ifdef IFQ_BYPASS_EN
    bypass        = run_q && !head_valid && rsp_keep;
`else
    bypass        = 1'b0;
`endif
    push          = rsp_keep && !(bypass && bus.inst_ready);
    pop           = head_valid && bus.inst_ready && !redirect;
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    run_d       = 1'b1;
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    drop_cnt_d  = drop_cnt_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    store_d     = store_q;
    in_flight_d = in_flight_q + cnt_t'(req_fire) - cnt_t'(bus.mem_rsp_valid);

    if (redirect) begin
      // Everything still outstanding (minus a response landing now) is stale.
      fetch_pc_d = redirect_addr;
      rsp_pc_d   = redirect_addr;
      drop_cnt_d = in_flight_q - cnt_t'(bus.mem_rsp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 64'd4;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + 64'd4;
      if (bus.mem_rsp_valid && rsp_drop) drop_cnt_d = drop_cnt_q - cnt_t'(1);
      if (push) begin
        store_d[wr_ptr_q] = '{data: bus.mem_rsp_data, pc: rsp_pc_q};
        wr_ptr_d          = wr_ptr_q + ptr_t'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q       <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      in_flight_q <= '0;
      drop_cnt_q  <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      // NOTE: queue storage is reset because inst/inst_pc read it directly and must be 0 in reset.
      store_q     <= '{default: '0};
    end else begin
      run_q       <= run_d;
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      in_flight_q <= in_flight_d;
      drop_cnt_q  <= drop_cnt_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      store_q     <= store_d;
    end
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.inst_valid    = head_valid || bypass;
  assign bus.inst          = bypass ? bus.mem_rsp_data : store_q[rd_ptr_q].data;
  assign bus.inst_pc       = bypass ? rsp_pc_q         : store_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: in-order memory model with random latency
// and a stream-level reference model (contiguous PCs from the last redirect target).
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;
`ifdef IFQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;

  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  pend_t       pending[$];
  int          cyc, since_reset, queued, n_req;
  logic [63:0] exp_req_addr, exp_pc;

  int          ready_pct, inst_ready_pct, lat_min, lat_max, req_limit, force_ready, redirect_pct;
  bit          redirect_once;
  logic [63:0] redirect_target;

  bit          obs_req_valid[$];
  logic [63:0] obs_req_addr[$];
  bit          obs_fire[$];
  bit          obs_rsp[$];
  bit          obs_inst_valid[$];
  logic [63:0] req_log[$];
  logic [63:0] pop_pc_log[$];
  logic [31:0] pop_data_log[$];
  int          pop_cyc_log[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h00C00293;
      64'h4:   return 32'h00500093;
      64'h8:   return 32'h00600113;
      default: return (a[33:2] * 32'h9E3779B1) ^ a[63:32];
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    redirect = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.inst_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    pending.delete();
    queued = 0; n_req = 0; since_reset = 0;
    exp_req_addr = RESET_PC; exp_pc = RESET_PC;
    ready_pct = 100; inst_ready_pct = 100; lat_min = 1; lat_max = 1;
    req_limit = -1; force_ready = -1; redirect_pct = 0; redirect_once = 1'b0;
    obs_req_valid.delete(); obs_req_addr.delete(); obs_fire.delete();
    obs_rsp.delete(); obs_inst_valid.delete(); req_log.delete();
    pop_pc_log.delete(); pop_data_log.delete(); pop_cyc_log.delete();
  endtask

  // One clock cycle: drive inputs, compare against the model away from the edge, advance the model.
  task automatic run_cycle();
    bit          do_redir, rsp_now, keep_rsp, exp_req_valid, exp_inst_valid, pop, fire, rdy;
    logic [63:0] rtarget;
    int          outstanding;
    pend_t       head;

    do_redir = redirect_once || ($urandom_range(99) < redirect_pct);
    rtarget  = redirect_once ? redirect_target : {$urandom(), $urandom()};
    redirect_once = 1'b0;
    redirect    = do_redir;
    redirect_pc = rtarget;
    rdy = (force_ready >= 0) ? (force_ready != 0) : ($urandom_range(99) < ready_pct);
    bus.mem_req_ready = rdy && (req_limit < 0 || n_req < req_limit);
    bus.inst_ready    = ($urandom_range(99) < inst_ready_pct);
    rsp_now = (pending.size() > 0) && (pending[0].due <= cyc);
    bus.mem_rsp_valid = rsp_now;
    bus.mem_rsp_data  = rsp_now ? mem_word(pending[0].addr) : $urandom();

    @(negedge clk);
    outstanding   = pending.size();
    keep_rsp      = rsp_now && !pending[0].stale && !do_redir;
    exp_req_valid = !do_redir && (outstanding + queued < DEPTH);
    checks++;
    if (since_reset == 0) begin
      if (bus.mem_req_valid === 1'b1 && !exp_req_valid) begin
        errors++;
        $display("FAIL req_valid_first cyc=%0d: got %b allowed %b", cyc, bus.mem_req_valid, exp_req_valid);
      end
    end else if (bus.mem_req_valid !== exp_req_valid) begin
      errors++;
      $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, bus.mem_req_valid, exp_req_valid);
    end
    if (bus.mem_req_valid === 1'b1 && exp_req_valid) begin
      checks++;
      if (bus.mem_req_addr !== exp_req_addr) begin
        errors++;
        $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, bus.mem_req_addr, exp_req_addr);
      end
    end
    exp_inst_valid = (queued > 0) || (BYPASS && keep_rsp);
    checks++;
    if (bus.inst_valid !== exp_inst_valid) begin
      errors++;
      $display("FAIL inst_valid cyc=%0d: got %b expected %b", cyc, bus.inst_valid, exp_inst_valid);
    end
    pop = exp_inst_valid && bus.inst_ready && !do_redir;
    if (pop) begin
      checks++;
      if (bus.inst_pc !== exp_pc || bus.inst !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL inst cyc=%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                 cyc, bus.inst_pc, bus.inst, exp_pc, mem_word(exp_pc));
      end
      pop_pc_log.push_back(bus.inst_pc);
      pop_data_log.push_back(bus.inst);
      pop_cyc_log.push_back(cyc);
      exp_pc += 64'd4;
    end
    fire = (bus.mem_req_valid === 1'b1) && bus.mem_req_ready;
    obs_req_valid.push_back(bus.mem_req_valid === 1'b1);
    obs_req_addr.push_back(bus.mem_req_addr);
    obs_fire.push_back(fire);
    obs_rsp.push_back(rsp_now);
    obs_inst_valid.push_back(bus.inst_valid === 1'b1);

    if (do_redir) begin
      foreach (pending[i]) pending[i].stale = 1'b1;
      queued       = 0;
      exp_req_addr = rtarget & ~64'h3;
      exp_pc       = rtarget & ~64'h3;
    end
    if (rsp_now) begin
      head = pending.pop_front();
      if (!head.stale) queued++;
    end
    if (pop) queued--;
    if (fire) begin
      pending.push_back('{addr: bus.mem_req_addr, due: cyc + $urandom_range(lat_max, lat_min), stale: 1'b0});
      req_log.push_back(bus.mem_req_addr);
      n_req++;
      exp_req_addr += 64'd4;
    end

    @(posedge clk);
    #1;
    cyc++;
    since_reset++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hDEADBEEF;
    bus.inst_ready    = 1'b1;
    @(posedge clk);
    #1;
    checks += 5;
    if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", bus.mem_req_valid); end
    if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b expected 0", bus.inst_valid); end
    if (bus.inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 0", bus.inst); end
    if (bus.inst_pc !== 64'h0) begin errors++; $display("FAIL rst_inst_pc: got %h expected 0", bus.inst_pc); end
    if (bus.mem_req_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr: got %h expected %h", bus.mem_req_addr, RESET_PC); end
  endtask

  task automatic test_in_order();
    logic [31:0] words [3];
    words[0] = 32'h00C00293; words[1] = 32'h00500093; words[2] = 32'h00600113;
    do_reset();
    repeat (20) run_cycle();
    checks++;
    if (pop_pc_log.size() < 12) begin
      errors++;
      $display("FAIL in_order_count: got %0d pops expected >= 12", pop_pc_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pop_pc_log[i] !== 64'(4 * i) || pop_data_log[i] !== words[i]) begin
          errors++;
          $display("FAIL in_order_%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                   i, pop_pc_log[i], pop_data_log[i], 64'(4 * i), words[i]);
        end
      end
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (pop_cyc_log[i+1] != pop_cyc_log[i] + 1) begin
          errors++;
          $display("FAIL throughput_%0d: got gap %0d expected 1", i, pop_cyc_log[i+1] - pop_cyc_log[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    inst_ready_pct = 0;
    repeat (12) run_cycle();
    checks++;
    if (req_log.size() != DEPTH) begin
      errors++;
      $display("FAIL bp_req_count: got %0d expected %0d", req_log.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (req_log[i] !== 64'(4 * i)) begin
          errors++;
          $display("FAIL bp_req_addr_%0d: got %h expected %h", i, req_log[i], 64'(4 * i));
        end
      end
    end
    checks++;
    if (obs_req_valid[obs_req_valid.size()-1] !== 1'b0) begin
      errors++;
      $display("FAIL bp_req_valid_full: got 1 expected 0");
    end
    inst_ready_pct = 100;
    repeat (12) run_cycle();
    checks++;
    if (req_log.size() <= DEPTH || req_log[DEPTH] !== 64'h10) begin
      errors++;
      $display("FAIL bp_next_req: got %h expected 10", (req_log.size() > DEPTH) ? req_log[DEPTH] : 64'hX);
    end
  endtask

  task automatic test_redirect();
    int req_mark, pop_mark;
    do_reset();
    lat_min = 3; lat_max = 3; req_limit = 2;
    for (int i = 0; i < 20 && n_req < 2; i++) run_cycle();
    checks++;
    if (n_req < 2) begin errors++; $display("FAIL redir_setup: got %0d requests expected 2", n_req); end
    req_mark = req_log.size();
    pop_mark = pop_pc_log.size();
    redirect_once = 1'b1;
    redirect_target = 64'h103;
    run_cycle();
    checks++;
    if (obs_req_valid[obs_req_valid.size()-1] !== 1'b0) begin
      errors++;
      $display("FAIL redir_cycle_req: got 1 expected 0");
    end
    req_limit = -1;
    repeat (15) run_cycle();
    checks += 2;
    if (req_log.size() <= req_mark || req_log[req_mark] !== 64'h100) begin
      errors++;
      $display("FAIL redir_req_addr: got %h expected 100", (req_log.size() > req_mark) ? req_log[req_mark] : 64'hX);
    end
    if (pop_pc_log.size() <= pop_mark || pop_pc_log[pop_mark] !== 64'h100) begin
      errors++;
      $display("FAIL redir_first_pc: got %h expected 100", (pop_pc_log.size() > pop_mark) ? pop_pc_log[pop_mark] : 64'hX);
    end
  endtask

  task automatic test_mem_stall();
    int          base;
    logic [63:0] stall_addr;
    do_reset();
    repeat (5) run_cycle();
    base = obs_req_valid.size();
    force_ready = 0;
    repeat (5) run_cycle();
    force_ready = 1;
    run_cycle();
    force_ready = 0;
    run_cycle();
    force_ready = -1;
    stall_addr = obs_req_addr[base];
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_req_valid[base+i] !== 1'b1 || obs_req_addr[base+i] !== stall_addr) begin
        errors++;
        $display("FAIL stall_hold_%0d: got valid=%b addr=%h expected valid=1 addr=%h",
                 i, obs_req_valid[base+i], obs_req_addr[base+i], stall_addr);
      end
    end
    checks += 2;
    if (obs_fire[base+5] !== 1'b1 || obs_req_addr[base+5] !== stall_addr) begin
      errors++;
      $display("FAIL stall_release: got fire=%b addr=%h expected fire=1 addr=%h",
               obs_fire[base+5], obs_req_addr[base+5], stall_addr);
    end
    if (obs_req_addr[base+6] !== stall_addr + 64'd4) begin
      errors++;
      $display("FAIL stall_advance: got %h expected %h", obs_req_addr[base+6], stall_addr + 64'd4);
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    inst_ready_pct = 0; req_limit = 3;
    for (int i = 0; i < 20 && !(queued == 3 && pending.size() == 0); i++) run_cycle();
    checks += 2;
    if (queued != 3) begin errors++; $display("FAIL rmid_setup: got %0d queued expected 3", queued); end
    if (bus.inst_valid !== 1'b1 || bus.mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_before: got inst_valid=%b req_valid=%b expected 1 1", bus.inst_valid, bus.mem_req_valid);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: got inst_valid=%b req_valid=%b expected 0 0", bus.inst_valid, bus.mem_req_valid);
    end
    do_reset();
    repeat (6) run_cycle();
    checks += 2;
    if (req_log.size() == 0 || req_log[0] !== RESET_PC) begin
      errors++;
      $display("FAIL rmid_restart_req: got %h expected %h", (req_log.size() > 0) ? req_log[0] : 64'hX, RESET_PC);
    end
    if (pop_pc_log.size() == 0 || pop_pc_log[0] !== RESET_PC) begin
      errors++;
      $display("FAIL rmid_restart_pc: got %h expected %h", (pop_pc_log.size() > 0) ? pop_pc_log[0] : 64'hX, RESET_PC);
    end
  endtask

  task automatic test_bypass();
    int n;
    do_reset();
    lat_min = 2; lat_max = 2; req_limit = 1;
    repeat (8) run_cycle();
    n = -1;
    for (int i = 0; i < obs_rsp.size(); i++) if (n < 0 && obs_rsp[i]) n = i;
    checks++;
    if (n < 0 || n + 1 >= obs_inst_valid.size()) begin
      errors++;
      $display("FAIL bypass_no_rsp: got no response expected one");
    end else begin
      checks++;
      if (obs_inst_valid[n] !== BYPASS || obs_inst_valid[n+1] !== !BYPASS) begin
        errors++;
        $display("FAIL bypass_timing: got N=%b N+1=%b expected N=%b N+1=%b",
                 obs_inst_valid[n], obs_inst_valid[n+1], BYPASS, !BYPASS);
      end
    end
  endtask

  task automatic test_pc_wrap();
    int          req_mark, pop_mark;
    logic [63:0] exp_addr [4];
    exp_addr[0] = 64'hFFFF_FFFF_FFFF_FFF8; exp_addr[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_addr[2] = 64'h0;                   exp_addr[3] = 64'h4;
    do_reset();
    repeat (3) run_cycle();
    redirect_once = 1'b1;
    redirect_target = 64'hFFFF_FFFF_FFFF_FFFB;
    req_mark = req_log.size();
    pop_mark = pop_pc_log.size();
    repeat (12) run_cycle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_log.size() <= req_mark + i || req_log[req_mark+i] !== exp_addr[i]) begin
        errors++;
        $display("FAIL wrap_req_%0d: got %h expected %h", i,
                 (req_log.size() > req_mark + i) ? req_log[req_mark+i] : 64'hX, exp_addr[i]);
      end
      checks++;
      if (pop_pc_log.size() <= pop_mark + i || pop_pc_log[pop_mark+i] !== exp_addr[i]) begin
        errors++;
        $display("FAIL wrap_pc_%0d: got %h expected %h", i,
                 (pop_pc_log.size() > pop_mark + i) ? pop_pc_log[pop_mark+i] : 64'hX, exp_addr[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    ready_pct = 70; inst_ready_pct = 60; lat_min = 1; lat_max = 4; redirect_pct = 3;
    repeat (3000) run_cycle();
    redirect_pct = 0; inst_ready_pct = 100; ready_pct = 100;
    repeat (30) run_cycle();
    checks++;
    if (pop_pc_log.size() < 500) begin
      errors++;
      $display("FAIL random_progress: got %0d pops expected >= 500", pop_pc_log.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    cyc = 0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.inst_ready    = 1'b0;
    test_reset();
    test_in_order();
    test_backpressure();
    test_redirect();
    test_mem_stall();
    test_reset_mid_stream();
    test_bypass();
    test_pc_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
